// File: rtl/i2s_adc_receiver.sv
// DSP-mode-B (LRC pulse, MSB on same BCLK) ADC deserialiser producing left/right PCM samples.
// Optional peak-magnitude tracker enabled by defining I2S_RX_PEAK_EN.
module i2s_adc_receiver #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  BCLK,
  input  logic                  ADC_LR_CLK,
  input  logic                  ADC_DATA,
  output logic [DATA_WIDTH-1:0] left_sample,
  output logic [DATA_WIDTH-1:0] right_sample,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  output logic                  frame_err,
`ifdef I2S_RX_PEAK_EN
  output logic [DATA_WIDTH-1:0] peak_level,
`endif
  input  logic                  clear_flags
);

  localparam int unsigned FrameLen = 2 * DATA_WIDTH;
  localparam int unsigned CntW     = $clog2(FrameLen + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FrameLen);
  localparam logic [CntW-1:0] CntLast = CntW'(FrameLen - 1);

  typedef enum logic [0:0] {StHunt, StRecv} state_e;

  logic [SYNC_STAGES-1:0] bclk_sync_q, lrc_sync_q, data_sync_q;
  logic                   bclk_prev_q;
  logic                   rise, lrc, din;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  // Holds all but the final bit; the last bit is taken straight from the synchroniser.
  logic [FrameLen-2:0]   shift_q, shift_d;
  logic [FrameLen-1:0]   shift_nxt;
  logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic [DATA_WIDTH-1:0] new_left, new_right;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic                  frame_err_q, frame_err_d;
  logic                  complete, load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_sync_q <= '0;
      lrc_sync_q  <= '0;
      data_sync_q <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], BCLK};
      lrc_sync_q  <= {lrc_sync_q[SYNC_STAGES-2:0], ADC_LR_CLK};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ADC_DATA};
      bclk_prev_q <= bclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
  assign lrc  = lrc_sync_q[SYNC_STAGES-1];
  assign din  = data_sync_q[SYNC_STAGES-1];

  assign shift_nxt = {shift_q, din};
  assign new_left  = shift_nxt[FrameLen-1 -: DATA_WIDTH];
  assign new_right = shift_nxt[DATA_WIDTH-1:0];

  // Frame assembly
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    complete    = 1'b0;
    if (!enable) begin
      state_d = StHunt;
      cnt_d   = '0;
    end else if (rise) begin
      unique case (state_q)
        StHunt: begin
          if (lrc) begin
            shift_d = {{(FrameLen-2){1'b0}}, din};
            cnt_d   = CntW'(1);
            state_d = StRecv;
          end
        end
        StRecv: begin
          if (lrc) begin
            // A start pulse before the frame filled means the previous frame was truncated.
            frame_err_d = (cnt_q != CntFull);
            shift_d     = {{(FrameLen-2){1'b0}}, din};
            cnt_d       = CntW'(1);
          end else if (cnt_q == CntFull) begin
            state_d = StHunt;
            cnt_d   = '0;
          end else begin
            shift_d  = shift_nxt[FrameLen-2:0];
            cnt_d    = cnt_q + 1'b1;
            complete = (cnt_q == CntLast);
          end
        end
        default: begin
          state_d = StHunt;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign load = complete && (!valid_q || sample_ready);

  // Output handshake and sticky overrun
  always_comb begin
    valid_d = valid_q;
    left_d  = left_q;
    right_d = right_q;
    ovr_d   = ovr_q;
    if (valid_q && sample_ready) valid_d = 1'b0;
    if (clear_flags) ovr_d = 1'b0;
    if (load) begin
      left_d  = new_left;
      right_d = new_right;
      valid_d = 1'b1;
    end else if (complete) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StHunt;
      cnt_q       <= '0;
      shift_q     <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign left_sample  = left_q;
  assign right_sample = right_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign frame_err    = frame_err_q;

`ifdef I2S_RX_PEAK_EN
  logic [DATA_WIDTH-1:0] peak_q, peak_d, mag_l, mag_r;

  // Saturating magnitude: the most negative code maps to the largest positive code.
  function automatic logic [DATA_WIDTH-1:0] sat_abs(input logic [DATA_WIDTH-1:0] x);
    if (!x[DATA_WIDTH-1]) return x;
    if (x == {1'b1, {(DATA_WIDTH-1){1'b0}}}) return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return ~x + 1'b1;
  endfunction

  assign mag_l = sat_abs(new_left);
  assign mag_r = sat_abs(new_right);

  always_comb begin
    peak_d = clear_flags ? '0 : peak_q;
    if (load) begin
      if (mag_l > peak_d) peak_d = mag_l;
      if (mag_r > peak_d) peak_d = mag_r;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) peak_q <= '0;
    else        peak_q <= peak_d;
  end

  assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Scoreboard bench for i2s_adc_receiver: BCLK = clk/16, queue-based frame model, random frames.
`timescale 1ns/1ps
module tb_i2s_adc_receiver;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic BCLK = 1'b0, ADC_LR_CLK = 1'b0, ADC_DATA = 1'b0;
  logic sample_ready = 1'b0, clear_flags = 1'b0;
  logic [DW-1:0] left_sample, right_sample;
  logic sample_valid, overrun, frame_err;
`ifdef I2S_RX_PEAK_EN
  logic [DW-1:0] peak_level;
  logic [DW-1:0] peak_model = '0;
`endif

  i2s_adc_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .BCLK         (BCLK),
    .ADC_LR_CLK   (ADC_LR_CLK),
    .ADC_DATA     (ADC_DATA),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .frame_err    (frame_err),
`ifdef I2S_RX_PEAK_EN
    .peak_level   (peak_level),
`endif
    .clear_flags  (clear_flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  logic ovr_model = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mag(input logic [DW-1:0] x);
    int v;
    v = $signed(x);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  // Monitor: every accepted sample must match the oldest expected frame.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (reset && frame_err) err_cnt++;
    if (reset && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_sample: got %h want none", {left_sample, right_sample});
      end else begin
        e = exp_q.pop_front();
        check("sample", {left_sample, right_sample}, e);
      end
    end
  end

  // Drive bits first..last of a frame; bit 0 carries the LRC pulse.
  task automatic send_bits(input logic [31:0] frame, input int first, input int last,
                           input bit lat_check, input bit ready_pulse);
    for (int i = first; i <= last; i++) begin
      BCLK       = 1'b0;
      ADC_LR_CLK = (i == 0);
      ADC_DATA   = frame[31-i];
      repeat (8) tick();
      BCLK = 1'b1;
      if (i == 31 && first == 0) begin
        tick();
        tick();
        if (lat_check) check("latency_early", 32'(sample_valid), 32'd0);
        if (ready_pulse) sample_ready = 1'b1;
        tick();
        if (ready_pulse) sample_ready = 1'b0;
        // A frame is kept only when the receiver holds no unaccepted sample.
        if (exp_q.size() == 0) begin
          exp_q.push_back(frame);
`ifdef I2S_RX_PEAK_EN
          if (mag(frame[31:16]) > int'(peak_model)) peak_model = DW'(mag(frame[31:16]));
          if (mag(frame[15:0]) > int'(peak_model)) peak_model = DW'(mag(frame[15:0]));
`endif
        end else begin
          ovr_model = 1'b1;
        end
        check("overrun", 32'(overrun), 32'(ovr_model));
        if (lat_check) check("latency_valid", 32'(sample_valid), 32'd1);
        if (ready_pulse) begin
          check("pulse_valid", 32'(sample_valid), 32'd1);
          check("pulse_data", {left_sample, right_sample}, frame);
        end
`ifdef I2S_RX_PEAK_EN
        check("peak", 32'(peak_level), 32'(peak_model));
`endif
        repeat (5) tick();
      end else begin
        repeat (8) tick();
      end
    end
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    ovr_model = 1'b0;
`ifdef I2S_RX_PEAK_EN
    peak_model = '0;
    check("peak_clear", 32'(peak_level), 32'd0);
`endif
    check("overrun_clear", 32'(overrun), 32'd0);
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (4) tick();
    check("rst_left", 32'(left_sample), 32'd0);
    check("rst_right", 32'(right_sample), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    reset  = 1'b1;
    enable = 1'b1;
    sample_ready = 1'b1;
    repeat (4) tick();

    // Back-to-back frames with an always-ready consumer
    send_bits(32'h1234_FEDC, 0, 31, 1'b1, 1'b0);
    send_bits(32'h8000_7FFF, 0, 31, 1'b1, 1'b0);
    check("no_frame_err", 32'(err_cnt), 32'd0);

    // Truncated frame then a clean one
    send_bits(32'hDEAD_BEEF, 0, 19, 1'b0, 1'b0);
    send_bits(32'hAAAA_5555, 0, 31, 1'b0, 1'b0);
    check("frame_err_once", 32'(err_cnt), 32'd1);

    // Overrun: consumer stalled across two frames
    sample_ready = 1'b0;
    send_bits(32'h0001_0002, 0, 31, 1'b0, 1'b0);
    send_bits(32'h0003_0004, 0, 31, 1'b0, 1'b0);
    check("hold_data", {left_sample, right_sample}, 32'h0001_0002);
    check("hold_valid", 32'(sample_valid), 32'd1);
    pulse_clear();
    sample_ready = 1'b1;
    repeat (4) tick();

    // Completion coinciding with the accept of the previous sample
    sample_ready = 1'b0;
    send_bits(32'h1111_2222, 0, 31, 1'b0, 1'b0);
    send_bits(32'h0BAD_BEEF, 0, 31, 1'b0, 1'b1);
    sample_ready = 1'b1;
    repeat (4) tick();

    // Enable dropped mid-frame: the tail must be ignored without error
    send_bits(32'h5A5A_A5A5, 0, 11, 1'b0, 1'b0);
    enable = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    send_bits(32'h5A5A_A5A5, 12, 31, 1'b0, 1'b0);
    send_bits(32'h1357_2468, 0, 31, 1'b0, 1'b0);
    check("enable_no_err", 32'(err_cnt), 32'd1);

    // Random frames with a randomly stalling consumer
    for (int k = 0; k < 8; k++) begin
      sample_ready = ($urandom_range(0, 3) != 0);
      send_bits($urandom, 0, 31, 1'b0, 1'b0);
    end
    sample_ready = 1'b1;
    repeat (4) tick();
    pulse_clear();

    // Reset in the middle of a frame
    sample_ready = 1'b0;
    send_bits(32'h7777_8888, 0, 31, 1'b0, 1'b0);
    send_bits(32'hCAFE_F00D, 0, 9, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    exp_q.delete();
    ovr_model = 1'b0;
    check("mid_rst_left", 32'(left_sample), 32'd0);
    check("mid_rst_right", 32'(right_sample), 32'd0);
    check("mid_rst_valid", 32'(sample_valid), 32'd0);
    check("mid_rst_frame_err", 32'(frame_err), 32'd0);
`ifdef I2S_RX_PEAK_EN
    peak_model = '0;
    check("mid_rst_peak", 32'(peak_level), 32'd0);
`endif
    repeat (3) tick();
    reset = 1'b1;
    sample_ready = 1'b1;
    send_bits(32'hCAFE_F00D, 10, 31, 1'b0, 1'b0);
    send_bits(32'h2468_1357, 0, 31, 1'b0, 1'b0);

    // Peak tracking frames (plain captures when the feature is absent)
    pulse_clear();
    send_bits(32'h0100_FF00, 0, 31, 1'b0, 1'b0);
    send_bits(32'h8000_0000, 0, 31, 1'b0, 1'b0);
    pulse_clear();

    repeat (20) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
